// File: rtl/arbiter_types.sv
// Shared types for the memory arbiter: FSM states, requester IDs and memory operations.
// Used by mem_arbiter.
package arbiter_types;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef enum logic {
      REQ_INSTR = 1'b0,
      REQ_DATA  = 1'b1
   } req_id_t;

   typedef enum logic [1:0] {
      OP_FETCH = 2'd0,
      OP_LOAD  = 2'd1,
      OP_STORE = 2'd2
   } mem_op_t;

   function automatic mem_op_t op_of(input req_id_t id, input logic we);
      if (id == REQ_INSTR) return OP_FETCH;
      return we ? OP_STORE : OP_LOAD;
   endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory between fetch and data ports.
// One transaction in flight; done pulses MEM_LAT+1 cycles after grant; requesters wait by holding req.
module mem_arbiter #(
   parameter int MEM_LAT = 2,
   parameter int DATA_W  = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_req,
   input  logic [63:0]       i_addr,
   output logic              i_done,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [63:0]       d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_done,
   output logic [DATA_W-1:0] d_rdata,
   output logic [63:0]       mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);
   import arbiter_types::*;

   localparam logic [2:0] LAST_CNT = 3'(MEM_LAT - 1);

   state_t            r_state;
   req_id_t           r_last;
   mem_op_t           r_op;
   logic [2:0]        r_cnt;
   logic              r_mem_we;
   logic              r_i_done;
   logic              r_d_done;
   logic [63:0]       r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic [DATA_W-1:0] r_i_rdata;
   logic [DATA_W-1:0] r_d_rdata;

   req_id_t w_pick;
   logic    w_grant;
   logic    w_last_busy;
   logic    w_i_ld;
   logic    w_d_ld;

   // r_last is the requester granted most recently; on a tie the other one wins.
   always_comb begin
      w_pick = REQ_INSTR;
      if (i_req && d_req) begin
         w_pick = (r_last == REQ_DATA) ? REQ_INSTR : REQ_DATA;
      end else if (d_req) begin
         w_pick = REQ_DATA;
      end
   end

   assign w_grant     = (r_state == IDLE) && (i_req || d_req);
   assign w_last_busy = (r_state == BUSY) && (r_cnt == LAST_CNT);
   assign w_i_ld      = w_last_busy && (r_op == OP_FETCH);
   assign w_d_ld      = w_last_busy && (r_op == OP_LOAD);

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_last      <= REQ_DATA;
         r_op        <= OP_FETCH;
         r_cnt       <= '0;
         r_mem_we    <= 1'b0;
         r_i_done    <= 1'b0;
         r_d_done    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else begin
         r_mem_we <= 1'b0;
         r_i_done <= 1'b0;
         r_d_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_grant) begin
                  r_state <= BUSY;
                  r_cnt   <= '0;
                  r_last  <= w_pick;
                  r_op    <= op_of(w_pick, d_we);
                  if (w_pick == REQ_DATA) begin
                     r_mem_addr  <= d_addr;
                     r_mem_wdata <= d_wdata;
                     r_mem_we    <= d_we;
                  end else begin
                     r_mem_addr  <= i_addr;
                     r_mem_wdata <= '0;
                  end
               end
            end
            BUSY: begin
               if (w_last_busy) begin
                  r_state  <= DONE;
                  r_i_done <= (r_op == OP_FETCH);
                  r_d_done <= (r_op != OP_FETCH);
               end else begin
                  r_cnt <= r_cnt + 3'd1;
               end
            end
            DONE: r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   // Read-data holding registers: load only when their own read completes.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_i_rdata <= '0;
      end else if (w_i_ld) begin
         r_i_rdata <= mem_rdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_d_rdata <= '0;
      end else if (w_d_ld) begin
         r_d_rdata <= mem_rdata;
      end
   end

   assign i_done    = r_i_done;
   assign d_done    = r_d_done;
   assign i_rdata   = r_i_rdata;
   assign d_rdata   = r_d_rdata;
   assign mem_addr  = r_mem_addr;
   assign mem_we    = r_mem_we;
   assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level model with a memory that only returns valid
// data in the cycle before capture; a second MEM_LAT=1 instance checks the short latency.
module tb_mem_arbiter;
   localparam int LAT = 2;

   typedef struct { bit is_d; int cyc; } dn_t;
   typedef struct { bit we; logic [63:0] addr; logic [63:0] wdata; } dreq_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        i_req, d_req, d_we;
   logic [63:0] i_addr, d_addr, d_wdata, mem_rdata;
   logic        i_done, d_done, mem_we;
   logic [63:0] i_rdata, d_rdata, mem_addr, mem_wdata;

   logic        i_req1;
   logic [63:0] i_addr1;
   logic        i_done1, d_done1, mem_we1;
   logic [63:0] i_rdata1, d_rdata1, mem_addr1, mem_wdata1;

   mem_arbiter #(.MEM_LAT(LAT), .DATA_W(64)) dut (
      .clk(clk), .reset(rst_n),
      .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_done(d_done), .d_rdata(d_rdata),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   mem_arbiter #(.MEM_LAT(1), .DATA_W(64)) dut1 (
      .clk(clk), .reset(rst_n),
      .i_req(i_req1), .i_addr(i_addr1), .i_done(i_done1), .i_rdata(i_rdata1),
      .d_req(1'b0), .d_we(1'b0), .d_addr(64'd0), .d_wdata(64'd0),
      .d_done(d_done1), .d_rdata(d_rdata1),
      .mem_addr(mem_addr1), .mem_we(mem_we1), .mem_wdata(mem_wdata1), .mem_rdata(64'hBEEF)
   );

   int checks = 0;
   int errors = 0;
   int n = 0;
   bit chk_en = 1'b0;

   // Model state: one outstanding transaction granted at edge g; arbiter free again at g+LAT+2.
   bit          m_busy, m_who_d, m_we, last_d, wd_valid;
   int          g;
   logic [63:0] m_addr, m_wdata;
   logic [63:0] e_addr, e_wdata, e_irdata, e_drdata;
   bit          e_we, e_idone, e_ddone, e_gd;
   logic [63:0] mem [logic [63:0]];

   logic [63:0] iq[$];
   dreq_t       dq[$];
   dn_t         done_q[$];
   bit          i_act, d_act, d_drop_early;

   function automatic logic [63:0] mrd(input logic [63:0] a);
      if (mem.exists(a)) return mem[a];
      return {a[31:0] ^ 32'h5A5A_C3C3, ~a[31:0]};
   endfunction

   function automatic logic [63:0] raddr();
      return 64'h100 + 64'($urandom_range(0, 7)) * 64'd8;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, n);
      end
   endtask

   task automatic chk_done(input int idx, input bit is_d, input int cyc);
      checks++;
      if (idx >= done_q.size()) begin
         errors++;
         $display("FAIL done[%0d]: missing, expected %s in cycle %0d", idx, is_d ? "d_done" : "i_done", cyc);
      end else if (done_q[idx].is_d != is_d || done_q[idx].cyc != cyc) begin
         errors++;
         $display("FAIL done[%0d]: got %s in cycle %0d, expected %s in cycle %0d", idx,
                  done_q[idx].is_d ? "d_done" : "i_done", done_q[idx].cyc,
                  is_d ? "d_done" : "i_done", cyc);
      end
   endtask

   task automatic push_d(input bit we, input logic [63:0] a, input logic [63:0] wd);
      dreq_t r;
      r.we = we; r.addr = a; r.wdata = wd;
      dq.push_back(r);
   endtask

   task automatic model_update();
      n++;
      e_gd = 1'b0;
      if (!rst_n) begin
         m_busy = 1'b0; last_d = 1'b1; wd_valid = 1'b1;
         e_addr = '0; e_wdata = '0; e_irdata = '0; e_drdata = '0;
      end else begin
         if (m_busy && n == g + LAT && !m_we) begin
            if (m_who_d) e_drdata = mrd(m_addr);
            else         e_irdata = mrd(m_addr);
         end
         if (m_busy && n >= g + LAT + 2) m_busy = 1'b0;
         if (!m_busy && (i_req || d_req)) begin
            m_who_d  = d_req && (!i_req || !last_d);
            last_d   = m_who_d;
            m_busy   = 1'b1;
            g        = n;
            m_addr   = m_who_d ? d_addr : i_addr;
            m_we     = m_who_d && d_we;
            m_wdata  = d_wdata;
            wd_valid = m_who_d;
            e_gd     = m_who_d;
            if (m_we) mem[m_addr] = m_wdata;
            e_addr  = m_addr;
            e_wdata = m_wdata;
         end
      end
      e_we    = m_busy && m_we && n == g;
      e_idone = m_busy && !m_who_d && n == g + LAT;
      e_ddone = m_busy && m_who_d && n == g + LAT;
   endtask

   // One clock: advance the model, then drive memory data and the two requesters.
   task automatic cycle_step();
      bit pi, pd;
      dreq_t r;
      pi = e_idone;
      pd = e_ddone;
      @(posedge clk);
      model_update();
      #1;
      if (m_busy && !m_we && n == g + LAT - 1) mem_rdata = mrd(m_addr);
      else                                     mem_rdata = {$urandom, $urandom};
      if (i_act && pi) begin
         i_req = 1'b0; i_act = 1'b0;
      end else if (!i_act && iq.size() > 0) begin
         i_addr = iq.pop_front(); i_req = 1'b1; i_act = 1'b1;
      end
      if (d_act && pd) begin
         d_req = 1'b0; d_act = 1'b0;
      end else if (d_act && d_drop_early && e_gd) begin
         d_req = 1'b0;
      end else if (!d_act && dq.size() > 0) begin
         r = dq.pop_front();
         d_we = r.we; d_addr = r.addr; d_wdata = r.wdata; d_req = 1'b1; d_act = 1'b1;
      end
   endtask

   task automatic wait_idle(input int max);
      int k;
      k = 0;
      while ((i_act || d_act || iq.size() != 0 || dq.size() != 0 || m_busy) && k < max) begin
         cycle_step();
         k++;
      end
      checks++;
      if (k >= max) begin
         errors++;
         $display("FAIL wait_idle: still busy after %0d cycles, expected idle", max);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0; i_req = 1'b0; d_req = 1'b0; i_act = 1'b0; d_act = 1'b0;
      cycle_step();
      rst_n = 1'b1;
   endtask

   initial begin : cmp
      dn_t dn;
      forever begin
         @(negedge clk);
         if (chk_en) begin
            chk("i_done", 64'(i_done), 64'(e_idone));
            chk("d_done", 64'(d_done), 64'(e_ddone));
            chk("mem_we", 64'(mem_we), 64'(e_we));
            chk("mem_addr", mem_addr, e_addr);
            chk("i_rdata", i_rdata, e_irdata);
            chk("d_rdata", d_rdata, e_drdata);
            if (wd_valid) chk("mem_wdata", mem_wdata, e_wdata);
            if (i_done) begin dn.is_d = 1'b0; dn.cyc = n; done_q.push_back(dn); end
            if (d_done) begin dn.is_d = 1'b1; dn.cyc = n; done_q.push_back(dn); end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      rst_n = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
      i_req1 = 1'b0; i_addr1 = '0;
      i_act = 1'b0; d_act = 1'b0; d_drop_early = 1'b0;
      m_busy = 1'b0; last_d = 1'b1; wd_valid = 1'b1; g = 0;
      m_who_d = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
      e_addr = '0; e_wdata = '0; e_irdata = '0; e_drdata = '0;
      e_we = 1'b0; e_idone = 1'b0; e_ddone = 1'b0; e_gd = 1'b0;
      mem[64'h10] = 64'hDEAD;
      mem[64'h18] = 64'h0123_4567_89AB_CDEF;

      cycle_step();
      chk_en = 1'b1;
      cycle_step();
      cycle_step();
      rst_n = 1'b1;
      chk("reset mem_addr", mem_addr, 64'd0);
      chk("reset d_rdata", d_rdata, 64'd0);

      // Fetch from 0x10: req driven in cycle t0 is sampled at the end of t0, done in t0+3.
      done_q.delete();
      iq.push_back(64'h10);
      cycle_step(); t0 = n;
      wait_idle(50);
      chk("fetch done count", 64'(done_q.size()), 64'd1);
      chk_done(0, 1'b0, t0 + 3);
      chk("fetch i_rdata", i_rdata, 64'hDEAD);

      // Store 0x1234 to 0x40: mem_we only in the first busy cycle.
      done_q.delete();
      push_d(1'b1, 64'h40, 64'h1234);
      cycle_step(); t0 = n;
      cycle_step();
      chk("store mem_we", 64'(mem_we), 64'd1);
      chk("store mem_addr", mem_addr, 64'h40);
      chk("store mem_wdata", mem_wdata, 64'h1234);
      cycle_step();
      chk("store mem_we second", 64'(mem_we), 64'd0);
      chk("store mem_addr held", mem_addr, 64'h40);
      wait_idle(50);
      chk_done(0, 1'b1, t0 + 3);
      chk("store d_rdata", d_rdata, 64'd0);

      // Simultaneous requests after reset: I, D, I, D four cycles apart.
      do_reset();
      done_q.delete();
      iq.push_back(64'h20); iq.push_back(64'h28);
      push_d(1'b0, 64'h30, 64'd0); push_d(1'b0, 64'h38, 64'd0);
      cycle_step(); t0 = n;
      wait_idle(100);
      chk("tie done count", 64'(done_q.size()), 64'd4);
      chk_done(0, 1'b0, t0 + 3);
      chk_done(1, 1'b1, t0 + 7);
      chk_done(2, 1'b0, t0 + 11);
      chk_done(3, 1'b1, t0 + 15);

      // Load to 0x80 interrupted by reset while busy.
      done_q.delete();
      push_d(1'b0, 64'h80, 64'd0);
      cycle_step();
      cycle_step();
      rst_n = 1'b0;
      cycle_step();
      d_req = 1'b0; d_act = 1'b0; rst_n = 1'b1;
      chk("abort mem_addr", mem_addr, 64'd0);
      chk("abort d_rdata", d_rdata, 64'd0);
      chk("abort i_rdata", i_rdata, 64'd0);
      chk("abort d_done", 64'(d_done), 64'd0);
      chk("abort lat1 mem_wdata", mem_wdata1, 64'd0);
      repeat (6) cycle_step();
      chk("abort no done", 64'(done_q.size()), 64'd0);
      iq.push_back(64'h10);
      cycle_step(); t0 = n;
      wait_idle(50);
      chk_done(0, 1'b0, t0 + 3);
      chk("after abort i_rdata", i_rdata, 64'hDEAD);

      // d_req released right after grant: transaction still completes.
      done_q.delete();
      d_drop_early = 1'b1;
      push_d(1'b0, 64'h18, 64'd0);
      cycle_step(); t0 = n;
      wait_idle(50);
      d_drop_early = 1'b0;
      chk_done(0, 1'b1, t0 + 3);
      chk("drop d_rdata", d_rdata, 64'h0123_4567_89AB_CDEF);

      // Random traffic over a small shared address window.
      for (int c = 0; c < 3000; c++) begin
         if (iq.size() == 0 && $urandom_range(0, 2) == 0) iq.push_back(raddr());
         if (dq.size() == 0 && $urandom_range(0, 2) == 0)
            push_d(1'($urandom_range(0, 1)), raddr(), {$urandom, $urandom});
         cycle_step();
      end
      wait_idle(100);

      // MEM_LAT=1 instance: done in the second cycle after the sampling edge.
      i_req1 = 1'b1; i_addr1 = 64'h10;
      cycle_step();
      chk("lat1 i_done busy", 64'(i_done1), 64'd0);
      chk("lat1 mem_addr", mem_addr1, 64'h10);
      chk("lat1 mem_we", 64'(mem_we1), 64'd0);
      cycle_step();
      chk("lat1 i_done", 64'(i_done1), 64'd1);
      chk("lat1 i_rdata", i_rdata1, 64'hBEEF);
      i_req1 = 1'b0;
      cycle_step();
      chk("lat1 i_done after", 64'(i_done1), 64'd0);
      chk("lat1 d_done", 64'(d_done1), 64'd0);
      chk("lat1 d_rdata", d_rdata1, 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 2: memory read latency in cycles from address presented to mem_rdata valid (legal range 1..7).
REQ-002 Parameter DATA_W, default 64: data width of both requesters and the memory port.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 i_req  input  1  instruction-fetch request, held high until i_done.
REQ-006 i_addr  input  64  fetch address.
REQ-007 i_done  output  1  one-cycle pulse: fetch complete, i_rdata valid.
REQ-008 i_rdata  output  DATA_W  fetched word.
REQ-009 d_req  input  1  data request, held high until d_done.
REQ-010 d_we  input  1  1 = store, 0 = load; sampled with d_req at grant.
REQ-011 d_addr  input  64  data address.
REQ-012 d_wdata  input  DATA_W  store data.
REQ-013 d_done  output  1  one-cycle pulse: load/store complete, d_rdata valid for loads.
REQ-014 d_rdata  output  DATA_W  loaded word.
REQ-015 mem_addr  output  64  shared memory address.
REQ-016 mem_we  output  1  shared memory write enable.
REQ-017 mem_wdata  output  DATA_W  shared memory write data.
REQ-018 mem_rdata  input  DATA_W  shared memory read data.

Function
REQ-019 The FSM shall have states IDLE, BUSY and DONE, with a single outstanding transaction at any time.
REQ-020 In IDLE with at least one req high, the next edge shall grant one requester, register its addr/we/wdata onto mem_addr/mem_we/mem_wdata, clear the latency counter and enter BUSY.
REQ-021 When i_req and d_req are both high in IDLE, the requester not served last shall win (round-robin); after reset, "last served" is data, so instruction wins the first tie.
REQ-022 Instruction grants shall always drive mem_we = 0.
REQ-023 mem_we shall be high only during the first BUSY cycle of a store grant and low in every other cycle.
REQ-024 mem_addr and mem_wdata shall hold their granted values throughout BUSY and DONE.
REQ-025 BUSY shall last exactly MEM_LAT cycles; on the last BUSY edge mem_rdata shall be captured into the granted requester's rdata register and the FSM shall enter DONE.
REQ-026 In DONE, the granted requester's done shall be high for exactly one cycle, after which the FSM shall return to IDLE unconditionally.
REQ-027 done shall rise MEM_LAT+1 cycles after the edge that sampled req; back-to-back throughput shall be one transaction per MEM_LAT+2 cycles.
REQ-028 The requester shall deassert req in the cycle following done; the arbiter shall not sample req during DONE.
REQ-029 A store shall leave d_rdata unchanged.
REQ-030 Each rdata register shall hold its last value until that requester's next load/fetch completes.
REQ-031 A req dropped mid-transaction shall not abort it; the transaction shall complete and done shall still pulse.
REQ-032 Only the granted requester's done shall ever pulse; i_done and d_done shall never be high together.

Reset
REQ-033 With reset low at a clock edge, the FSM shall enter IDLE and i_done, d_done and mem_we shall be 0.
REQ-034 The same reset edge shall clear mem_addr, mem_wdata, i_rdata, d_rdata and the latency counter to 0, and set last-served to data.
REQ-035 Reset asserted during BUSY or DONE shall discard the transaction with no done pulse; a store whose mem_we cycle already occurred is not undone.

Structure
REQ-036 The state enum (IDLE/BUSY/DONE) and the requester-ID enum (REQ_INSTR/REQ_DATA) shall live in a shared package, arbiter_types, alongside opcodes and operations.
REQ-037 The module shall be a single flat module with no sub-modules; the rdata registers shall use the existing reg_ld style of load-enabled register behaviour.

Verification
REQ-038 Reset, then i_req=1, i_addr=0x10, mem returns 0xDEAD after MEM_LAT=2 -> i_done pulses exactly 3 cycles after the sampling edge, i_rdata=0xDEAD, mem_we stays 0.
REQ-039 d_req=1, d_we=1, d_addr=0x40, d_wdata=0x1234 -> mem_we high for exactly one cycle with mem_addr=0x40 and mem_wdata=0x1234; d_done pulses; d_rdata unchanged.
REQ-040 i_req and d_req raised in the same cycle after reset, both held and re-raised after each done -> grant order is I, D, I, D, with transactions 4 cycles apart.
REQ-041 Start a load to 0x80, then drive reset low during BUSY -> no d_done, outputs zeroed on the next edge, and a fresh i_req afterwards completes normally.
REQ-042 d_req dropped one cycle after grant -> d_done still pulses at the normal cycle with correct d_rdata.
REQ-043 MEM_LAT=1 build, repeat REQ-038 -> i_done pulses 2 cycles after the sampling edge.
